// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA test-pattern path: 640x480@60 timing,
// pattern encodings, fade range and the pattern scheduler state type.
package vga_pkg;

    localparam int unsigned H_DISPLAY = 640;
    localparam int unsigned H_FRONT   = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BACK    = 48;
    localparam int unsigned H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;

    localparam int unsigned V_DISPLAY = 480;
    localparam int unsigned V_FRONT   = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BACK    = 33;
    localparam int unsigned V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [1:0] PAT_BARS     = 2'd0;
    localparam logic [1:0] PAT_CHECKER  = 2'd1;
    localparam logic [1:0] PAT_GRADIENT = 2'd2;
    localparam logic [1:0] PAT_CIRCLE   = 2'd3;

    localparam logic [3:0] FADE_MAX = 4'hF;

    typedef enum logic [1:0] {
        SHOW     = 2'd0,
        FADE_OUT = 2'd1,
        SWAP     = 2'd2,
        FADE_IN  = 2'd3
    } sched_state_t;

    // Auto mode steps through the four patterns, wrapping 3 -> 0.
    function automatic logic [1:0] next_pattern(input logic [1:0] pat);
        return pat + 2'd1;
    endfunction

endpackage

// File: rtl/vga_pattern_scheduler_if.sv
// Switch/frame inputs and pattern/fade outputs of the pattern scheduler,
// bundled so the timing block, switches and pattern generator share one port.
interface vga_pattern_scheduler_if;

    logic       frame_start;
    logic [1:0] sw;
    logic       auto_en;
    logic [1:0] pattern_sel;
    logic [3:0] fade_level;
    logic       busy;
    logic       pattern_changed;

    modport master (
        output frame_start, sw, auto_en,
        input  pattern_sel, fade_level, busy, pattern_changed
    );

    modport slave (
        input  frame_start, sw, auto_en,
        output pattern_sel, fade_level, busy, pattern_changed
    );

endinterface

// File: rtl/vga_input_conditioner.sv
// Two-flop synchroniser for asynchronous board inputs, with an optional
// per-bit stability filter enabled by the VGA_SCHED_DEBOUNCE_EN macro.
module vga_input_conditioner #(
    parameter int unsigned WIDTH           = 1,
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic             clk_pix,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] clean
);

    logic [WIDTH-1:0] meta;
    logic [WIDTH-1:0] sync;

    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= raw;
            sync <= meta;
        end
    end

`ifdef VGA_SCHED_DEBOUNCE_EN
    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(DEBOUNCE_CYCLES - 1);

    // Each bit is binary, so "stable for N cycles" is the same as "differing
    // from the accepted value for N consecutive cycles".
    for (genvar i = 0; i < WIDTH; i++) begin : g_debounce
        logic [CW-1:0] cnt;
        logic          stable;

        always_ff @(posedge clk_pix or posedge rst) begin
            if (rst) begin
                cnt    <= '0;
                stable <= 1'b0;
            end else if (sync[i] == stable) begin
                cnt <= '0;
            end else if (cnt == LAST_CNT) begin
                cnt    <= '0;
                stable <= sync[i];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign clean[i] = stable;
    end
`else
    assign clean = sync;
`endif

endmodule

// File: rtl/vga_pattern_scheduler.sv
// Frame-synchronous test-pattern selector with fade-out / swap / fade-in
// sequencing. Optional input debounce: define VGA_SCHED_DEBOUNCE_EN.
module vga_pattern_scheduler
    import vga_pkg::*;
#(
    parameter int unsigned FRAMES_PER_PATTERN = 120,
    parameter int unsigned DEBOUNCE_CYCLES    = 250000
) (
    input logic                    clk_pix,
    input logic                    rst,
    vga_pattern_scheduler_if.slave bus
);

    localparam int unsigned FW = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;
    localparam logic [FW-1:0] LAST_FRAME = FW'(FRAMES_PER_PATTERN - 1);

    logic [2:0]   cond;
    logic [1:0]   sw_s;
    logic         auto_s;

    sched_state_t state;
    sched_state_t state_next;
    logic [FW-1:0] frame_cnt;
    logic [1:0]   pattern_sel;
    logic [1:0]   pending;
    logic [1:0]   target;
    logic [3:0]   fade_level;
    logic         frame_wrap;
    logic         start_change;
    logic         busy;
    logic         pattern_changed;

    vga_input_conditioner #(
        .WIDTH           (3),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_input_conditioner (
        .clk_pix (clk_pix),
        .rst     (rst),
        .raw     ({bus.auto_en, bus.sw}),
        .clean   (cond)
    );

    assign {auto_s, sw_s} = cond;

    assign frame_wrap = bus.frame_start && (frame_cnt == LAST_FRAME);

    // In auto mode the target only moves on the frame that completes the dwell.
    always_comb begin
        target = sw_s;
        if (auto_s) begin
            target = frame_wrap ? next_pattern(pattern_sel) : pattern_sel;
        end
    end

    assign start_change = bus.frame_start && (target != pattern_sel);

    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (state != SHOW || !auto_s) begin
            frame_cnt <= '0;
        end else if (bus.frame_start) begin
            frame_cnt <= frame_wrap ? '0 : frame_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            state <= SHOW;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            SHOW:     if (start_change) state_next = FADE_OUT;
            FADE_OUT: if (bus.frame_start && fade_level == 4'd1) state_next = SWAP;
            SWAP:     state_next = FADE_IN;
            FADE_IN:  if (bus.frame_start && fade_level == FADE_MAX - 4'd1) state_next = SHOW;
            default:  state_next = SHOW;
        endcase
    end

    always_comb begin
        busy            = (state != SHOW);
        pattern_changed = (state == SWAP);
    end

    // The frame that starts a change is also the first fade step, so a full
    // fade-out spans exactly 15 frame_starts.
    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            fade_level  <= FADE_MAX;
            pattern_sel <= PAT_BARS;
            pending     <= PAT_BARS;
        end else begin
            case (state)
                SHOW: begin
                    fade_level <= FADE_MAX;
                    if (start_change) begin
                        fade_level <= FADE_MAX - 4'd1;
                        pending    <= target;
                    end
                end
                FADE_OUT: if (bus.frame_start && fade_level != 4'd0) fade_level <= fade_level - 4'd1;
                SWAP:     pattern_sel <= pending;
                FADE_IN:  if (bus.frame_start && fade_level != FADE_MAX) fade_level <= fade_level + 4'd1;
                default:  fade_level <= FADE_MAX;
            endcase
        end
    end

    assign bus.pattern_sel     = pattern_sel;
    assign bus.fade_level      = fade_level;
    assign bus.busy            = busy;
    assign bus.pattern_changed = pattern_changed;

endmodule

// File: tb/tb_vga_pattern_scheduler.sv
// Self-checking bench for vga_pattern_scheduler: a frame-level model checked
// every cycle plus directed scenarios with literal expectations.
module tb_vga_pattern_scheduler;

    localparam int FPP          = 4;
    localparam int DBC          = 8;
    localparam int FRAME_PERIOD = 50;
    localparam int SIG_BUSY     = 0;
    localparam int SIG_FADE     = 1;
    localparam int SIG_CHANGED  = 2;

    logic clk_pix = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   fs_edges = 0;

    vga_pattern_scheduler_if bus ();

    vga_pattern_scheduler #(
        .FRAMES_PER_PATTERN (FPP),
        .DEBOUNCE_CYCLES    (DBC)
    ) dut (
        .clk_pix (clk_pix),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 clk_pix = ~clk_pix;

    always @(posedge clk_pix) if (bus.frame_start) fs_edges++;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A change is tracked as the number of frame_starts consumed (1..30);
    // brightness is derived from that count, the swap sits between 15 and 16.
    logic [2:0] m_h0 = '0, m_h1 = '0, m_eff;
`ifdef VGA_SCHED_DEBOUNCE_EN
    logic [2:0]     m_db = '0;
    logic [DBC-1:0] m_win [3];
`endif
    int m_sel = 0, m_pend = 0, m_done = 0, m_frames = 0, m_lvl = 15, m_tgt;
    bit m_busy = 0, m_swap = 0;

    always @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            m_h0 = '0; m_h1 = '0;
`ifdef VGA_SCHED_DEBOUNCE_EN
            m_db = '0;
            for (int b = 0; b < 3; b++) m_win[b] = '0;
`endif
            m_sel = 0; m_pend = 0; m_done = 0; m_frames = 0; m_busy = 0; m_swap = 0;
        end else begin
`ifdef VGA_SCHED_DEBOUNCE_EN
            m_eff = m_db;
`else
            m_eff = m_h1;
`endif
            if (!m_busy) begin
                m_tgt = m_eff[1:0];
                if (m_eff[2]) begin
                    m_tgt = m_sel;
                    if (bus.frame_start) begin
                        if (m_frames == FPP - 1) begin
                            m_frames = 0;
                            m_tgt = (m_sel + 1) % 4;
                        end else begin
                            m_frames++;
                        end
                    end
                end else begin
                    m_frames = 0;
                end
                if (bus.frame_start && m_tgt != m_sel) begin
                    m_busy = 1; m_done = 1; m_pend = m_tgt;
                end
            end else begin
                m_frames = 0;
                if (m_swap) begin
                    m_sel = m_pend; m_swap = 0;
                end else if (bus.frame_start) begin
                    m_done++;
                    if (m_done == 15) m_swap = 1;
                    if (m_done == 30) m_busy = 0;
                end
            end
`ifdef VGA_SCHED_DEBOUNCE_EN
            for (int b = 0; b < 3; b++) begin
                m_win[b] = {m_win[b][DBC-2:0], m_h1[b]};
                if (m_win[b] == {DBC{~m_db[b]}}) m_db[b] = ~m_db[b];
            end
`endif
            m_h1 = m_h0;
            m_h0 = {bus.auto_en, bus.sw};
        end
        m_lvl = !m_busy ? 15 : (m_done <= 15 ? 15 - m_done : m_done - 15);
    end

    always @(negedge clk_pix) begin
        if (rst === 1'b0) begin
            check("model_pattern_sel", bus.pattern_sel, m_sel);
            check("model_fade_level", bus.fade_level, m_lvl);
            check("model_busy", bus.busy, m_busy);
            check("model_pattern_changed", bus.pattern_changed, m_swap);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bus.frame_start = 1'b0;
        forever begin
            repeat (FRAME_PERIOD - 1) @(posedge clk_pix);
            #1 bus.frame_start = 1'b1;
            @(posedge clk_pix);
            #1 bus.frame_start = 1'b0;
        end
    end

    task automatic wait_for(input int sig, input int val, input int budget, input string name);
        int cur;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_pix);
            case (sig)
                SIG_BUSY:    cur = bus.busy;
                SIG_FADE:    cur = bus.fade_level;
                SIG_CHANGED: cur = bus.pattern_changed;
                default:     cur = bus.pattern_sel;
            endcase
            if (cur == val) return;
        end
        checks++;
        failures++;
        $display("FAIL %s: timed out after %0d cycles, wanted %0d", name, budget, val);
    endtask

    // Returns on the negedge just before the edge that samples frame_start.
    task automatic align_frame();
        for (int i = 0; i < 2 * FRAME_PERIOD; i++) begin
            @(negedge clk_pix);
            if (bus.frame_start) return;
        end
        checks++;
        failures++;
        $display("FAIL frame_align: no frame_start within %0d cycles", 2 * FRAME_PERIOD);
    endtask

    int t0, t1, base, seen;
    int auto_seq [4] = '{1, 2, 3, 0};

    initial begin
        rst = 1'b1;
        bus.sw = 2'd0;
        bus.auto_en = 1'b0;
        repeat (3) @(posedge clk_pix);
        #1 rst = 1'b0;
        @(negedge clk_pix);
        check("reset_pattern_sel", bus.pattern_sel, 0);
        check("reset_fade_level", bus.fade_level, 15);
        check("reset_busy", bus.busy, 0);
        check("reset_pattern_changed", bus.pattern_changed, 0);

        // Manual change 0 -> 2
        bus.sw = 2'd2;
        wait_for(SIG_BUSY, 1, 2 * FRAME_PERIOD, "manual_start");
        t0 = fs_edges;
        check("manual_first_step", bus.fade_level, 14);
        wait_for(SIG_FADE, 0, 16 * FRAME_PERIOD, "manual_black");
        t1 = fs_edges;
        check("fadeout_frames", t1 - t0, 14);
        check("swap_pulse", bus.pattern_changed, 1);
        check("swap_sel_before", bus.pattern_sel, 0);
        @(negedge clk_pix);
        check("swap_sel_after", bus.pattern_sel, 2);
        check("swap_pulse_end", bus.pattern_changed, 0);
        wait_for(SIG_BUSY, 0, 16 * FRAME_PERIOD, "manual_done");
        check("fadein_frames", fs_edges - t1, 15);
        check("manual_final_fade", bus.fade_level, 15);
        check("manual_final_sel", bus.pattern_sel, 2);

        // Target change while busy is frozen out
        bus.sw = 2'd3;
        wait_for(SIG_BUSY, 1, 2 * FRAME_PERIOD, "busy_chg_start");
        repeat (3 * FRAME_PERIOD) @(negedge clk_pix);
        bus.sw = 2'd1;
        wait_for(SIG_BUSY, 0, 31 * FRAME_PERIOD, "busy_chg_done");
        check("busy_chg_frozen_sel", bus.pattern_sel, 3);
        t0 = fs_edges;
        wait_for(SIG_BUSY, 1, 2 * FRAME_PERIOD, "busy_chg_restart");
        check("busy_chg_restart_frames", fs_edges - t0, 1);
        wait_for(SIG_BUSY, 0, 31 * FRAME_PERIOD, "busy_chg_done2");
        check("busy_chg_final_sel", bus.pattern_sel, 1);

`ifdef VGA_SCHED_DEBOUNCE_EN
        // Five-cycle glitch must not start a fade
        align_frame();
        bus.sw = 2'd0;
        repeat (5) @(negedge clk_pix);
        bus.sw = 2'd1;
        seen = 0;
        repeat (3 * FRAME_PERIOD) begin
            @(negedge clk_pix);
            if (bus.busy) seen = 1;
        end
        check("debounce_glitch_ignored", seen, 0);
        bus.sw = 2'd2;
        wait_for(SIG_BUSY, 1, 3 * FRAME_PERIOD, "debounce_accept");
        wait_for(SIG_BUSY, 0, 31 * FRAME_PERIOD, "debounce_done");
        check("debounce_final_sel", bus.pattern_sel, 2);
`else
        // Input sampled one edge too late misses the next frame
        align_frame();
        repeat (49) @(posedge clk_pix);
        #1 bus.sw = 2'd3;
        repeat (3) @(negedge clk_pix);
        check("latency_late_missed", bus.busy, 0);
        repeat (50) @(negedge clk_pix);
        check("latency_late_next_frame", bus.busy, 1);
        wait_for(SIG_BUSY, 0, 31 * FRAME_PERIOD, "latency_late_done");
        check("latency_late_sel", bus.pattern_sel, 3);
        // Input sampled just in time (2-cycle synchroniser) catches the frame
        align_frame();
        repeat (48) @(posedge clk_pix);
        #1 bus.sw = 2'd2;
        repeat (4) @(negedge clk_pix);
        check("latency_ontime_taken", bus.busy, 1);
        wait_for(SIG_BUSY, 0, 31 * FRAME_PERIOD, "latency_ontime_done");
        check("latency_ontime_sel", bus.pattern_sel, 2);
`endif

        // Auto cycling 0 -> 1 -> 2 -> 3 -> 0, four frames per pattern
        align_frame();
        rst = 1'b1;
        bus.sw = 2'd0;
        bus.auto_en = 1'b1;
        @(negedge clk_pix);
        rst = 1'b0;
        base = fs_edges;
        for (int k = 0; k < 4; k++) begin
            wait_for(SIG_BUSY, 1, 6 * FRAME_PERIOD, "auto_start");
            check("auto_dwell_frames", fs_edges - base, FPP);
            wait_for(SIG_CHANGED, 1, 16 * FRAME_PERIOD, "auto_swap");
            @(negedge clk_pix);
            check("auto_pattern", bus.pattern_sel, auto_seq[k]);
            wait_for(SIG_BUSY, 0, 16 * FRAME_PERIOD, "auto_done");
            base = fs_edges;
        end

        // Asynchronous reset during fade-in at level 7
        bus.auto_en = 1'b0;
        bus.sw = 2'd2;
        wait_for(SIG_CHANGED, 1, 17 * FRAME_PERIOD, "midreset_swap");
        wait_for(SIG_FADE, 7, 8 * FRAME_PERIOD, "midreset_level7");
        check("midreset_pre_sel", bus.pattern_sel, 2);
        #3 rst = 1'b1;
        #1;
        check("midreset_pattern_sel", bus.pattern_sel, 0);
        check("midreset_fade_level", bus.fade_level, 15);
        check("midreset_busy", bus.busy, 0);
        check("midreset_pattern_changed", bus.pattern_changed, 0);
        repeat (2) @(negedge clk_pix);
        rst = 1'b0;
        repeat (4) @(negedge clk_pix);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
